oam_dma_controller: RTL and testbench

- Sequences the NES sprite DMA ($4014) by sharing the single-port work RAM and PPU bus between the CPU and the DMA engine.
- On a CPU write to DMA_REG_ADDR it halts the CPU, becomes bus master, and copies 256 bytes from page {data,8'h00} to OAM_DATA_ADDR.
- It then returns the bus to the CPU.
- Sits between the CPU core, the RAM controller and the PPU register decoder; all bus steps advance on CPU-cycle strobes.

---
 rtl/oam_dma_controller.sv | 144 ++++++++++++++
 tb/tb_oam_dma_controller.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_controller.sv
`default_nettype none
// ============================================================================
// Module   : oam_dma_controller
// Brief    : NES sprite DMA ($4014) sequencer. Halts the CPU and copies one RAM
//            page to the OAM data port. Optional macro: OAM_DMA_DEBUG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module oam_dma_controller #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
    parameter int          XFER_BYTES    = 256
) (
    input  logic        dma_clk_in,
    input  logic        dma_reset_in,
    input  logic        cpu_cycle_in,
    input  logic [15:0] cpu_address_in,
    input  logic [7:0]  cpu_data_in,
    input  logic        cpu_write_in,
    input  logic [7:0]  dma_data_in,
    output logic        cpu_rdy_out,
    output logic        bus_master_out,
    output logic [15:0] dma_address_out,
    output logic [7:0]  dma_data_out,
    output logic        dma_read_out,
    output logic        dma_write_out,
    output logic        busy_out,
    output logic [15:0] debug_out
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HALT  = 3'd1;
    localparam logic [2:0] S_ALIGN = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;

    localparam logic [7:0] c_last_idx = 8'(XFER_BYTES - 1);

    logic [2:0] r_state;
    logic [2:0] w_state_next;
    logic [7:0] r_page;
    logic [7:0] r_idx;
    logic       r_parity;
    logic [7:0] r_data;
    logic       w_reg_hit;
    logic       w_trigger;

    assign w_reg_hit = cpu_cycle_in && cpu_write_in && (cpu_address_in == DMA_REG_ADDR);
    assign w_trigger = w_reg_hit && (r_state == S_IDLE);

    always_ff @(posedge dma_clk_in) begin
        if (dma_reset_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The alignment decision looks at parity as it will be after this strobe's toggle.
    always_comb begin
        w_state_next = r_state;
        if (cpu_cycle_in) begin
            case (r_state)
                S_IDLE:  if (w_trigger) w_state_next = S_HALT;
                S_HALT:  w_state_next = (~r_parity) ? S_ALIGN : S_READ;
                S_ALIGN: w_state_next = S_READ;
                S_READ:  w_state_next = S_WRITE;
                S_WRITE: w_state_next = (r_idx == c_last_idx) ? S_IDLE : S_READ;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        cpu_rdy_out     = 1'b1;
        bus_master_out  = 1'b0;
        busy_out        = 1'b0;
        dma_address_out = 16'h0000;
        dma_read_out    = 1'b0;
        dma_write_out   = 1'b0;
        case (r_state)
            S_HALT, S_ALIGN: begin
                cpu_rdy_out = 1'b0;
                busy_out    = 1'b1;
            end
            S_READ: begin
                cpu_rdy_out     = 1'b0;
                busy_out        = 1'b1;
                bus_master_out  = 1'b1;
                dma_address_out = {r_page, r_idx};
                dma_read_out    = 1'b1;
            end
            S_WRITE: begin
                cpu_rdy_out     = 1'b0;
                busy_out        = 1'b1;
                bus_master_out  = 1'b1;
                dma_address_out = OAM_DATA_ADDR;
                dma_write_out   = 1'b1;
            end
            default: ;
        endcase
    end

    // RAM q is held while rden is low, so sampling it every WRITE clock is safe.
    always_ff @(posedge dma_clk_in) begin
        if (dma_reset_in) begin
            r_page   <= 8'h00;
            r_idx    <= 8'h00;
            r_parity <= 1'b0;
            r_data   <= 8'h00;
        end else begin
            if (cpu_cycle_in) r_parity <= ~r_parity;
            if (w_trigger) begin
                r_page <= cpu_data_in;
                r_idx  <= 8'h00;
            end else if (cpu_cycle_in && (r_state == S_WRITE) && (r_idx != c_last_idx)) begin
                r_idx <= r_idx + 8'd1;
            end
            if (r_state == S_WRITE) r_data <= dma_data_in;
        end
    end

    assign dma_data_out = r_data;

`ifdef OAM_DMA_DEBUG_EN
    logic [14:0] r_debug_lo;
    logic        r_sticky;

    always_ff @(posedge dma_clk_in) begin
        if (dma_reset_in) begin
            r_debug_lo <= 15'h0000;
            r_sticky   <= 1'b0;
        end else begin
            r_debug_lo <= {r_page[6:0], r_idx};
            if (w_reg_hit && (r_state != S_IDLE)) r_sticky <= 1'b1;
        end
    end

    assign debug_out = {r_sticky, r_debug_lo};
`else
    assign debug_out = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_oam_dma_controller.sv
`default_nettype none
// Self-checking bench for oam_dma_controller: randomized RAM contents and trigger
// phase, checked against a transfer-level expectation of the copied page.
module tb_oam_dma_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_cycle_in = 1'b0;
    logic [15:0] cpu_address_in = 16'h0000;
    logic [7:0]  cpu_data_in = 8'h00;
    logic        cpu_write_in = 1'b0;
    logic [7:0]  ram_q = 8'h00;
    logic        cpu_rdy_out, bus_master_out, dma_read_out, dma_write_out, busy_out;
    logic [15:0] dma_address_out, debug_out;
    logic [7:0]  dma_data_out;

    oam_dma_controller dut (
        .dma_clk_in     (clk),
        .dma_reset_in   (rst),
        .cpu_cycle_in   (cpu_cycle_in),
        .cpu_address_in (cpu_address_in),
        .cpu_data_in    (cpu_data_in),
        .cpu_write_in   (cpu_write_in),
        .dma_data_in    (ram_q),
        .cpu_rdy_out    (cpu_rdy_out),
        .bus_master_out (bus_master_out),
        .dma_address_out(dma_address_out),
        .dma_data_out   (dma_data_out),
        .dma_read_out   (dma_read_out),
        .dma_write_out  (dma_write_out),
        .busy_out       (busy_out),
        .debug_out      (debug_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0]  mem [0:65535];
    logic [15:0] raddr_q [$];
    logic [15:0] waddr_q [$];
    logic [7:0]  wdata_q [$];
    int          halt_cnt = 0;
    int          viol = 0;
    int          strobe_cnt = 0;
    bit          stuck = 1'b0;
    bit          pend_wr = 1'b0;

    // Registered RAM: q updates only while rden is high.
    always @(posedge clk) if (dma_read_out) ram_q <= mem[dma_address_out];

    always @(posedge clk) begin
        if (rst) strobe_cnt <= 0;
        else if (cpu_cycle_in) strobe_cnt <= strobe_cnt + 1;
    end

    initial begin : strobe_gen
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            cnt = (cnt + 1) % 4;
            cpu_cycle_in = stuck ? 1'b1 : (cnt == 0);
        end
    end

    always @(negedge clk) begin
        if (pend_wr) begin
            wdata_q.push_back(dma_data_out);
            pend_wr = 1'b0;
        end
        if (!rst) begin
            if (dma_read_out && cpu_cycle_in) raddr_q.push_back(dma_address_out);
            if (dma_write_out && cpu_cycle_in) begin
                waddr_q.push_back(dma_address_out);
                pend_wr = 1'b1;
            end
            if (cpu_cycle_in && !cpu_rdy_out) halt_cnt++;
        end
        if (dma_read_out && dma_write_out) viol++;
        if ((dma_read_out || dma_write_out) && (!busy_out || !bus_master_out)) viol++;
    end

    task automatic wait_strobe();
        do @(posedge clk); while (!cpu_cycle_in);
        #2;
    endtask

    task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data,
                             input int want_par, output int par);
        wait_strobe();
        while (want_par < 2 && (strobe_cnt % 2) != want_par) wait_strobe();
        par = strobe_cnt % 2;
        cpu_address_in = addr;
        cpu_data_in    = data;
        cpu_write_in   = 1'b1;
        wait_strobe();
        cpu_write_in   = 1'b0;
        cpu_address_in = 16'h0000;
    endtask

    task automatic clear_log();
        raddr_q.delete();
        waddr_q.delete();
        wdata_q.delete();
        halt_cnt = 0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (busy_out && n < 6000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy_out) begin
            failures++;
            $display("FAIL done_timeout: busy_out=%0b required 0 after %0d clocks", busy_out, n);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_transfer(input string name, input logic [7:0] page, input int par);
        int exp_halt;
        logic [15:0] ea;
        exp_halt = (par == 0) ? 513 : 514;
        checks++;
        if (halt_cnt !== exp_halt) begin
            failures++;
            $display("FAIL %s_halt: got %0d required %0d", name, halt_cnt, exp_halt);
        end
        checks++;
        if (raddr_q.size() != 256 || waddr_q.size() != 256 || wdata_q.size() != 256) begin
            failures++;
            $display("FAIL %s_count: reads=%0d writes=%0d data=%0d required 256", name,
                     raddr_q.size(), waddr_q.size(), wdata_q.size());
        end else begin
            for (int i = 0; i < 256; i++) begin
                ea = {page, 8'(i)};
                checks++;
                if (raddr_q[i] !== ea || waddr_q[i] !== 16'h2004 || wdata_q[i] !== mem[ea]) begin
                    failures++;
                    $display("FAIL %s_byte%0d: rd=%h wr=%h data=%h required rd=%h wr=2004 data=%h",
                             name, i, raddr_q[i], waddr_q[i], wdata_q[i], ea, mem[ea]);
                end
            end
        end
        checks++;
        if (cpu_rdy_out !== 1'b1 || bus_master_out !== 1'b0 || busy_out !== 1'b0) begin
            failures++;
            $display("FAIL %s_release: rdy=%b bm=%b busy=%b required 1 0 0", name,
                     cpu_rdy_out, bus_master_out, busy_out);
        end
    endtask

    task automatic run_dma(input string name, input logic [7:0] page, input int want_par,
                           input bit retrig);
        int par, dummy;
        clear_log();
        cpu_write(16'h4014, page, want_par, par);
        if (retrig) begin
            repeat (5) wait_strobe();
            cpu_write(16'h4014, ~page, 2, dummy);
        end
        wait_done();
        check_transfer(name, page, par);
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (cpu_rdy_out !== 1'b1 || bus_master_out !== 1'b0 || busy_out !== 1'b0 ||
            dma_address_out !== 16'h0 || dma_data_out !== 8'h0 || dma_read_out !== 1'b0 ||
            dma_write_out !== 1'b0 || debug_out !== 16'h0) begin
            failures++;
            $display("FAIL reset_values: rdy=%b bm=%b busy=%b addr=%h data=%h rd=%b wr=%b dbg=%h required 1 0 0 0000 00 0 0 0000",
                     cpu_rdy_out, bus_master_out, busy_out, dma_address_out, dma_data_out,
                     dma_read_out, dma_write_out, debug_out);
        end
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            wait_strobe();
            if (cpu_rdy_out !== 1'b1 || bus_master_out || dma_read_out || dma_write_out) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL idle_quiet: bad cycles=%0d required 0", bad);
        end
    endtask

    task automatic test_no_trigger();
        int dummy;
        clear_log();
        cpu_write(16'h4015, 8'h03, 2, dummy);
        cpu_write(16'h2004, 8'h04, 2, dummy);
        repeat (10) wait_strobe();
        checks++;
        if (busy_out !== 1'b0 || cpu_rdy_out !== 1'b1 || raddr_q.size() != 0 || halt_cnt != 0) begin
            failures++;
            $display("FAIL no_trigger: busy=%b rdy=%b reads=%0d halts=%0d required 0 1 0 0",
                     busy_out, cpu_rdy_out, raddr_q.size(), halt_cnt);
        end
    endtask

    task automatic test_mid_reset();
        int par, n;
        logic [7:0] page;
        page = 8'($urandom_range(8, 255));
        cpu_write(16'h4014, page, 2, par);
        n = 0;
        while (!(dma_read_out && dma_address_out == {page, 8'h80}) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            failures++;
            $display("FAIL mid_reach: addr=%h required %h", dma_address_out, {page, 8'h80});
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (cpu_rdy_out !== 1'b1 || bus_master_out !== 1'b0 || busy_out !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: rdy=%b bm=%b busy=%b required 1 0 0",
                     cpu_rdy_out, bus_master_out, busy_out);
        end
        @(negedge clk);
        rst = 1'b0;
        run_dma("restart", 8'($urandom_range(8, 255)), 2, 1'b0);
    endtask

    task automatic test_busy_retrigger();
        run_dma("retrig", 8'($urandom_range(8, 255)), 2, 1'b1);
        checks++;
`ifdef OAM_DMA_DEBUG_EN
        if (debug_out[15] !== 1'b1) begin
            failures++;
            $display("FAIL debug_sticky: got %b required 1", debug_out[15]);
        end
`else
        if (debug_out !== 16'h0000) begin
            failures++;
            $display("FAIL debug_tied: got %h required 0000", debug_out);
        end
`endif
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (debug_out !== 16'h0000) begin
            failures++;
            $display("FAIL debug_reset: got %h required 0000", debug_out);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[{8'h02, 8'(i)}] = 8'(i) ^ 8'h5A;
        test_reset();
        test_no_trigger();
        run_dma("even", 8'h02, 0, 1'b0);
        run_dma("odd", 8'h02, 1, 1'b0);
        for (int k = 0; k < 2; k++) run_dma("random", 8'($urandom_range(0, 255)), 2, 1'b0);
        stuck = 1'b1;
        repeat (2) @(posedge clk);
        run_dma("stuck", 8'h07, 2, 1'b0);
        stuck = 1'b0;
        test_mid_reset();
        test_busy_retrigger();
        checks++;
        if (viol != 0) begin
            failures++;
            $display("FAIL strobe_rules: violations=%0d required 0", viol);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
